// File: rtl/johnson_mon_pkg.sv
// Shared definitions for the Johnson phase monitor: FSM state encoding,
// default phase width and the modulo phase increment.
package johnson_mon_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] LOCK  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_TRACK = TRACK,
        ST_LOCK  = LOCK
    } mon_state_e;

    localparam int unsigned N_DEFAULT = 4;
    localparam int unsigned PHASE_W   = $clog2(2 * N_DEFAULT);

    // Increment modulo the number of legal phases (2N).
    function automatic int unsigned next_phase(input int unsigned p,
                                               input int unsigned n_phases);
        return (p + 1 == n_phases) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational decode of one Johnson code into legality, phase index and
// a one-hot phase vector (all zero when the code is not a Johnson state).
module johnson_phase_decode #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(2 * N)
) (
    input  logic [N-1:0]   c_i,
    output logic           legal_o,
    output logic [PW-1:0]  phase_o,
    output logic [2*N-1:0] onehot_o
);

    logic [N-1:0] c_inv;
    int unsigned  ones;

    assign c_inv = ~c_i;

    // A legal code is a run of ones anchored at bit 0 (filling phase) or a
    // run of ones anchored at the MSB (draining phase); x & (x+1) == 0
    // tests for a contiguous run starting at bit 0.
    always_comb begin
        ones = 0;
        for (int i = 0; i < int'(N); i++) begin
            ones += int'(c_i[i]);
        end

        if (c_i[N-1]) begin
            legal_o = ((c_inv & (c_inv + N'(1))) == '0);
        end else begin
            legal_o = ((c_i & (c_i + N'(1))) == '0);
        end

        if (!c_i[N-1]) begin
            phase_o = PW'(ones);
        end else if (c_inv == '0) begin
            phase_o = PW'(N);
        end else begin
            phase_o = PW'(2 * N - ones);
        end
    end

    for (genvar gi = 0; gi < int'(2 * N); gi++) begin : g_onehot
        assign onehot_o[gi] = legal_o && (phase_o == PW'(gi));
    end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Monitors a sampled Johnson counter: decodes phase, checks each step
// against the legal sequence, acquires/holds lock and counts faults.
module johnson_phase_monitor
    import johnson_mon_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned LOCK_CNT = 4,
    parameter bit          HOLD_OK  = 1'b1,
    parameter int unsigned ERR_W    = 8,
    localparam int unsigned PW      = $clog2(2 * N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             jc_valid_i,
    input  logic [N-1:0]     jc_i,
    input  logic             clr_err_i,
    output logic [PW-1:0]    phase_o,
    output logic [2*N-1:0]   phase_oh_o,
    output logic             phase_vld_o,
    output logic             wrap_o,
    output logic             illegal_o,
    output logic             locked_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam int unsigned NPH   = 2 * N;
    localparam int unsigned CNT_W = 4;

    logic             dec_legal;
    logic [PW-1:0]    dec_phase;
    logic [2*N-1:0]   dec_oh;

    mon_state_e       state_q;
    logic [PW-1:0]    prev_q;
    logic [CNT_W-1:0] good_cnt_q;
    logic [PW-1:0]    phase_q;
    logic [2*N-1:0]   phase_oh_q;
    logic             phase_vld_q;
    logic             wrap_q;
    logic             illegal_q;
    logic             locked_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;

    logic [PW-1:0]    step_next;
    logic             step_good;
    logic             wrap_hit;
    logic             fault;

    johnson_phase_decode #(
        .N  (N),
        .PW (PW)
    ) u_decode (
        .c_i      (jc_i),
        .legal_o  (dec_legal),
        .phase_o  (dec_phase),
        .onehot_o (dec_oh)
    );

    assign step_next = PW'(next_phase(int'(prev_q), NPH));
    assign step_good = dec_legal &&
                       ((dec_phase == step_next) || (HOLD_OK && (dec_phase == prev_q)));
    assign wrap_hit  = step_good && (prev_q == PW'(NPH - 1)) && (dec_phase == '0);

    // Without a reference only the code itself can be wrong; with one, the step must be good too.
    assign fault = jc_valid_i && ((state_q == ST_IDLE) ? !dec_legal : !step_good);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            phase_q     <= '0;
            phase_oh_q  <= '0;
            phase_vld_q <= 1'b0;
            wrap_q      <= 1'b0;
            illegal_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            phase_vld_q <= 1'b0;
            wrap_q      <= 1'b0;
            illegal_q   <= 1'b0;

            if (jc_valid_i) begin
                illegal_q <= fault;

                if (dec_legal) begin
                    phase_q     <= dec_phase;
                    phase_oh_q  <= dec_oh;
                    phase_vld_q <= 1'b1;
                end else begin
                    phase_oh_q  <= '0;
                end

                case (state_q)
                    ST_IDLE: begin
                        if (dec_legal) begin
                            prev_q     <= dec_phase;
                            good_cnt_q <= '0;
                            state_q    <= ST_TRACK;
                        end
                    end
                    ST_TRACK, ST_LOCK: begin
                        if (step_good) begin
                            prev_q <= dec_phase;
                            wrap_q <= wrap_hit;
                            if (state_q == ST_TRACK) begin
                                good_cnt_q <= good_cnt_q + CNT_W'(1);
                                if (good_cnt_q + CNT_W'(1) == CNT_W'(LOCK_CNT)) begin
                                    state_q  <= ST_LOCK;
                                    locked_q <= 1'b1;
                                end
                            end
                        end else begin
                            // A decodable code after a bad step reseeds tracking.
                            locked_q   <= 1'b0;
                            good_cnt_q <= '0;
                            if (dec_legal) begin
                                prev_q  <= dec_phase;
                                state_q <= ST_TRACK;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Clear wins over a coincident fault; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err_i) begin
            err_cnt_d = '0;
        end else if (fault && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign phase_o     = phase_q;
    assign phase_oh_o  = phase_oh_q;
    assign phase_vld_o = phase_vld_q;
    assign wrap_o      = wrap_q;
    assign illegal_o   = illegal_q;
    assign locked_o    = locked_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench: three monitor configurations share one stimulus
// stream; directed scenarios plus a randomized run against a table model.
module tb_johnson_phase_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       jc_valid = 1'b0;
    logic [3:0] jc = 4'h0;
    logic       clr_err = 1'b0;

    // index 0: HOLD_OK=1 ERR_W=8, 1: HOLD_OK=0 ERR_W=8, 2: HOLD_OK=1 ERR_W=2
    logic [2:0] d_phase [3];
    logic [7:0] d_oh    [3];
    logic       d_vld   [3];
    logic       d_wrap  [3];
    logic       d_ill   [3];
    logic       d_lock  [3];
    logic [7:0] err_a, err_b;
    logic [1:0] err_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    johnson_phase_monitor #(.N(4), .LOCK_CNT(4), .HOLD_OK(1'b1), .ERR_W(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .jc_valid_i(jc_valid), .jc_i(jc), .clr_err_i(clr_err),
        .phase_o(d_phase[0]), .phase_oh_o(d_oh[0]), .phase_vld_o(d_vld[0]), .wrap_o(d_wrap[0]),
        .illegal_o(d_ill[0]), .locked_o(d_lock[0]), .err_cnt_o(err_a));

    johnson_phase_monitor #(.N(4), .LOCK_CNT(4), .HOLD_OK(1'b0), .ERR_W(8)) u_dut_h0 (
        .clk_i(clk), .rst_ni(rst_n), .jc_valid_i(jc_valid), .jc_i(jc), .clr_err_i(clr_err),
        .phase_o(d_phase[1]), .phase_oh_o(d_oh[1]), .phase_vld_o(d_vld[1]), .wrap_o(d_wrap[1]),
        .illegal_o(d_ill[1]), .locked_o(d_lock[1]), .err_cnt_o(err_b));

    johnson_phase_monitor #(.N(4), .LOCK_CNT(4), .HOLD_OK(1'b1), .ERR_W(2)) u_dut_e2 (
        .clk_i(clk), .rst_ni(rst_n), .jc_valid_i(jc_valid), .jc_i(jc), .clr_err_i(clr_err),
        .phase_o(d_phase[2]), .phase_oh_o(d_oh[2]), .phase_vld_o(d_vld[2]), .wrap_o(d_wrap[2]),
        .illegal_o(d_ill[2]), .locked_o(d_lock[2]), .err_cnt_o(err_c));

    // ---------------- reference model ----------------
    int jtab [8];
    int hold_ok [3] = '{1, 0, 1};
    int err_max [3] = '{255, 255, 3};
    int m_phase [3], m_oh [3], m_vld [3], m_wrap [3], m_ill [3], m_lock [3], m_err [3];
    int has_ref [3], prev [3], streak [3];

    function automatic int lookup(input logic [3:0] c);
        for (int k = 0; k < 8; k++) if (jtab[k] == int'(c)) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_phase[i] = 0; m_oh[i] = 0; m_vld[i] = 0; m_wrap[i] = 0;
            m_ill[i] = 0; m_lock[i] = 0; m_err[i] = 0;
            has_ref[i] = 0; prev[i] = 0; streak[i] = 0;
        end
    endtask

    task automatic model_step(input bit v, input logic [3:0] c, input bit clr);
        int k;
        int fault;
        int good;
        k = lookup(c);
        for (int i = 0; i < 3; i++) begin
            m_vld[i] = 0; m_wrap[i] = 0; m_ill[i] = 0;
            fault = 0;
            if (v) begin
                if (k >= 0) begin
                    m_phase[i] = k; m_oh[i] = 1 << k; m_vld[i] = 1;
                end else begin
                    m_oh[i] = 0;
                end
                if (has_ref[i] == 0) begin
                    if (k < 0) fault = 1;
                    else begin has_ref[i] = 1; prev[i] = k; streak[i] = 0; end
                end else begin
                    good = (k >= 0) && (k == (prev[i] + 1) % 8 || (hold_ok[i] != 0 && k == prev[i]));
                    if (good != 0) begin
                        if (prev[i] == 7 && k == 0) m_wrap[i] = 1;
                        prev[i] = k;
                        if (m_lock[i] == 0) begin
                            streak[i]++;
                            if (streak[i] == 4) m_lock[i] = 1;
                        end
                    end else begin
                        fault = 1; m_lock[i] = 0; streak[i] = 0;
                        if (k >= 0) prev[i] = k; else has_ref[i] = 0;
                    end
                end
                m_ill[i] = fault;
            end
            if (clr) m_err[i] = 0;
            else if (fault != 0 && m_err[i] < err_max[i]) m_err[i]++;
        end
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic cyc(input bit v, input logic [3:0] c, input bit clr);
        jc_valid = v; jc = c; clr_err = clr;
        @(posedge clk);
        model_step(v, c, clr);
        @(negedge clk);
        jc_valid = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] code_of(input int k);
        logic [3:0] c;
        c = 4'(jtab[k % 8]);
        return c;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        cyc(1, 4'b0101, 0);
        cyc(1, 4'b0000, 0);
        cyc(1, 4'b0001, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({d_phase[0], d_oh[0], d_vld[0], d_wrap[0], d_ill[0], d_lock[0]} !== 15'h0)
            $display("FAIL reset_outputs: got phase=%0d oh=%h vld=%0b wrap=%0b ill=%0b lock=%0b want all 0",
                     d_phase[0], d_oh[0], d_vld[0], d_wrap[0], d_ill[0], d_lock[0]);
        else n_pass++;
        n_checks++;
        if (err_a !== 8'd0) $display("FAIL reset_err: got %0d want 0", err_a); else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 4'b0001, 0);
        n_checks++;
        if (d_phase[0] !== 3'd1) $display("FAIL post_reset_phase: got %0d want 1", d_phase[0]); else n_pass++;
        n_checks++;
        if (d_oh[0] !== 8'h02) $display("FAIL post_reset_oh: got %h want 02", d_oh[0]); else n_pass++;
        n_checks++;
        if (d_vld[0] !== 1'b1 || d_lock[0] !== 1'b0 || d_ill[0] !== 1'b0)
            $display("FAIL post_reset_flags: got vld=%0b lock=%0b ill=%0b want 1 0 0", d_vld[0], d_lock[0], d_ill[0]);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_clean_sequence();
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            cyc(1, code_of(k), 0);
            n_checks++;
            if (d_phase[0] !== 3'(k % 8) || d_vld[0] !== 1'b1)
                $display("FAIL clean_phase[%0d]: got %0d vld=%0b want %0d vld=1", k, d_phase[0], d_vld[0], k % 8);
            else n_pass++;
            n_checks++;
            if (d_lock[0] !== (k >= 4)) $display("FAIL clean_lock[%0d]: got %0b want %0b", k, d_lock[0], k >= 4);
            else n_pass++;
            n_checks++;
            if (d_wrap[0] !== (k == 8)) $display("FAIL clean_wrap[%0d]: got %0b want %0b", k, d_wrap[0], k == 8);
            else n_pass++;
        end
        n_checks++;
        if (err_a !== 8'd0) $display("FAIL clean_err: got %0d want 0", err_a); else n_pass++;
        $display("test_clean_sequence done");
    endtask

    task automatic test_illegal_in_lock();
        cyc(1, 4'b0101, 0);
        n_checks++;
        if (d_ill[0] !== 1'b1 || d_vld[0] !== 1'b0 || d_oh[0] !== 8'h00 || d_lock[0] !== 1'b0)
            $display("FAIL bad_code_flags: got ill=%0b vld=%0b oh=%h lock=%0b want 1 0 00 0",
                     d_ill[0], d_vld[0], d_oh[0], d_lock[0]);
        else n_pass++;
        n_checks++;
        if (err_a !== 8'd1 || d_phase[0] !== 3'd0)
            $display("FAIL bad_code_err: got err=%0d phase=%0d want 1 0", err_a, d_phase[0]);
        else n_pass++;
        cyc(1, 4'b0011, 0);
        n_checks++;
        if (d_phase[0] !== 3'd2 || d_vld[0] !== 1'b1 || d_ill[0] !== 1'b0 || err_a !== 8'd1)
            $display("FAIL reacquire: got phase=%0d vld=%0b ill=%0b err=%0d want 2 1 0 1",
                     d_phase[0], d_vld[0], d_ill[0], err_a);
        else n_pass++;
        $display("test_illegal_in_lock done");
    endtask

    task automatic test_skip_in_lock();
        do_reset();
        for (int k = 0; k <= 10; k++) cyc(1, code_of(k), 0);
        cyc(1, 4'b1111, 0);
        n_checks++;
        if (d_ill[0] !== 1'b1 || d_phase[0] !== 3'd4 || d_vld[0] !== 1'b1 || d_lock[0] !== 1'b0 || err_a !== 8'd1)
            $display("FAIL skip_step: got ill=%0b phase=%0d vld=%0b lock=%0b err=%0d want 1 4 1 0 1",
                     d_ill[0], d_phase[0], d_vld[0], d_lock[0], err_a);
        else n_pass++;
        for (int s = 1; s <= 4; s++) begin
            cyc(1, code_of(4 + s), 0);
            n_checks++;
            if (d_lock[0] !== (s == 4)) $display("FAIL relock[%0d]: got %0b want %0b", s, d_lock[0], s == 4);
            else n_pass++;
        end
        $display("test_skip_in_lock done");
    endtask

    task automatic test_hold();
        do_reset();
        for (int k = 0; k <= 11; k++) cyc(1, code_of(k), 0);
        n_checks++;
        if (d_lock[0] !== 1'b1 || d_lock[1] !== 1'b1)
            $display("FAIL hold_prelock: got %0b %0b want 1 1", d_lock[0], d_lock[1]);
        else n_pass++;
        for (int r = 1; r <= 2; r++) begin
            cyc(1, 4'b0111, 0);
            n_checks++;
            if (d_ill[0] !== 1'b0 || d_lock[0] !== 1'b1)
                $display("FAIL hold_ok1[%0d]: got ill=%0b lock=%0b want 0 1", r, d_ill[0], d_lock[0]);
            else n_pass++;
            if (r == 1) begin
                n_checks++;
                if (d_ill[1] !== 1'b1 || d_lock[1] !== 1'b0 || d_phase[1] !== 3'd3)
                    $display("FAIL hold_ok0: got ill=%0b lock=%0b phase=%0d want 1 0 3", d_ill[1], d_lock[1], d_phase[1]);
                else n_pass++;
            end
        end
        n_checks++;
        if (err_b !== 8'd2 || err_a !== 8'd0) $display("FAIL hold_err: got %0d %0d want 2 0", err_b, err_a);
        else n_pass++;
        $display("test_hold done");
    endtask

    task automatic test_err_sat();
        do_reset();
        for (int f = 1; f <= 5; f++) begin
            cyc(1, 4'b0101, 0);
            n_checks++;
            if (err_c !== 2'((f > 3) ? 3 : f)) $display("FAIL err_sat[%0d]: got %0d want %0d", f, err_c, (f > 3) ? 3 : f);
            else n_pass++;
        end
        n_checks++;
        if (err_a !== 8'd5) $display("FAIL err_wide: got %0d want 5", err_a); else n_pass++;
        cyc(1, 4'b0101, 1);
        n_checks++;
        if (err_c !== 2'd0 || err_a !== 8'd0 || d_ill[2] !== 1'b1)
            $display("FAIL err_clr: got err=%0d/%0d ill=%0b want 0/0 1", err_c, err_a, d_ill[2]);
        else n_pass++;
        $display("test_err_sat done");
    endtask

    task automatic test_random();
        int gp;
        int r;
        logic [3:0] c;
        bit v;
        bit clr;
        logic [7:0] e;
        do_reset();
        gp = 0;
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      begin gp = (gp + 1) % 8; c = code_of(gp); end
            else if (r < 65) c = code_of(gp);
            else if (r < 75) begin gp = int'($urandom_range(0, 7)); c = code_of(gp); end
            else             c = 4'($urandom_range(0, 15));
            v   = ($urandom_range(0, 99) < 85);
            clr = ($urandom_range(0, 99) < 4);
            cyc(v, c, clr);
            for (int i = 0; i < 3; i++) begin
                e = (i == 0) ? err_a : (i == 1) ? err_b : {6'b0, err_c};
                n_checks++;
                if (d_phase[i] !== m_phase[i] || d_oh[i] !== m_oh[i] || d_vld[i] !== m_vld[i] ||
                    d_wrap[i] !== m_wrap[i] || d_ill[i] !== m_ill[i] || d_lock[i] !== m_lock[i] || e !== m_err[i])
                    $display("FAIL random[%0d] cfg%0d code=%b v=%0b: got ph=%0d oh=%h vld=%0b wr=%0b ill=%0b lk=%0b err=%0d want ph=%0d oh=%h vld=%0d wr=%0d ill=%0d lk=%0d err=%0d",
                             n, i, c, v, d_phase[i], d_oh[i], d_vld[i], d_wrap[i], d_ill[i], d_lock[i], e,
                             m_phase[i], m_oh[i], m_vld[i], m_wrap[i], m_ill[i], m_lock[i], m_err[i]);
                else n_pass++;
            end
        end
        $display("test_random done");
    endtask

    initial begin
        for (int k = 0; k < 8; k++) jtab[k] = (k <= 4) ? ((1 << k) - 1) : (15 ^ ((1 << (k - 4)) - 1));
        model_reset();
        test_reset();
        test_clean_sequence();
        test_illegal_in_lock();
        test_skip_in_lock();
        test_hold();
        test_err_sat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
